// File: rtl/dm_resp.sv
`default_nettype none
// ============================================================================
// Module   : dm_resp
// Brief    : Word-addressed data memory with a one-outstanding request /
//            response handshake, fixed read latency and byte-enabled writes.
// Revision : 1.0 - initial release
// ============================================================================
module dm_resp #(
    parameter int NWORDS = 128,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [2:0] LAT_M1    = 3'(RD_LAT - 1);
    localparam logic [7:0] NWORDS_W  = 8'(NWORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [NWORDS];

    logic          accept;
    logic          in_range;
    logic [AW-1:0] idx;

    // Full 7-bit compare so upper address bits never alias into the array.
    assign in_range  = ({1'b0, req_addr} < NWORDS_W);
    assign idx       = req_addr[AW-1:0];
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = (!req_wr && in_range) ? mem[idx] : 32'h0;
                    err_d   = !in_range;
                    if (req_wr || (RD_LAT == 1)) begin
                        state_d = RESP;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; acceptance already excludes reset cycles.
    always_ff @(posedge clk) begin
        if (accept && req_wr && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid ? err_q : 1'b0;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_resp
// Brief    : Self-checking bench for dm_resp; four instances with different
//            NWORDS / RD_LAT checked against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_resp;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NI-1:0]   req_valid, req_wr, rsp_ready;
    logic [6:0]      req_addr  [NI];
    logic [31:0]     req_wdata [NI];
    logic [3:0]      req_be    [NI];
    wire  [NI-1:0]   req_ready, rsp_valid, rsp_err, busy;
    wire  [31:0]     rsp_rdata [NI];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [NI][128];

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int nw_of(input int i);
        return (i == 0) ? 64 : 128;
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            dm_resp #(
                .NWORDS ((g == 0) ? 64 : 128),
                .RD_LAT ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 7)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .req_valid (req_valid[g]),
                .req_ready (req_ready[g]),
                .req_wr    (req_wr[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .req_be    (req_be[g]),
                .rsp_valid (rsp_valid[g]),
                .rsp_ready (rsp_ready[g]),
                .rsp_rdata (rsp_rdata[g]),
                .rsp_err   (rsp_err[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    // Runs one transaction from a falling edge; returns what was observed.
    task automatic xact(input int i, input logic wr, input logic [6:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int hold,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int hold_bad, output int zero_bad, output logic after_ok);
        int n;
        lat = -1; rd = '0; er = 1'b0; hold_bad = 0; zero_bad = 0; after_ok = 1'b0;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid[i] = 1'b1; req_wr[i] = wr; req_addr[i] = addr;
        req_wdata[i] = wd;   req_be[i] = be; rsp_ready[i] = (hold == 0);
        @(negedge clk);
        if (wr && int'(addr) < nw_of(i))
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[i][addr][8*b +: 8] = wd[8*b +: 8];
        req_valid[i] = 1'b0;     req_wr[i] = 1'($urandom);  req_addr[i] = 7'($urandom);
        req_wdata[i] = $urandom; req_be[i] = 4'($urandom);
        n = 1;
        while (rsp_valid[i] !== 1'b1 && n < 20) begin
            if (rsp_rdata[i] !== 32'h0 || rsp_err[i] !== 1'b0) zero_bad++;
            @(negedge clk);
            n++;
        end
        if (rsp_valid[i] !== 1'b1) begin
            rsp_ready[i] = 1'b0;
            return;
        end
        lat = n; rd = rsp_rdata[i]; er = rsp_err[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid[i] !== 1'b1 || rsp_rdata[i] !== rd || rsp_err[i] !== er ||
                req_ready[i] !== 1'b0) hold_bad++;
        end
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        after_ok = (rsp_valid[i] === 1'b0 && req_ready[i] === 1'b1 &&
                    rsp_rdata[i] === 32'h0 && rsp_err[i] === 1'b0);
        rsp_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({req_ready[i], rsp_valid[i], busy[i], rsp_err[i]} !== 4'b0 || rsp_rdata[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got ready/valid/busy/err=%b rdata=%h, expected 0000 / 0",
                         i, {req_ready[i], rsp_valid[i], busy[i], rsp_err[i]}, rsp_rdata[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (req_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
                n_err++;
                $display("FAIL ready_after_reset[%0d]: got ready=%b busy=%b, expected 1 0",
                         i, req_ready[i], busy[i]);
            end
        end
    endtask

    task automatic test_fill();
        int lat, hb, zb; logic [31:0] rd; logic er, ok;
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < nw_of(i); a++) begin
                xact(i, 1'b1, 7'(a), $urandom, 4'hF, 0, lat, rd, er, hb, zb, ok);
                n_vec++;
                if (lat !== 1 || er !== 1'b0 || rd !== 32'h0 || ok !== 1'b1) begin
                    n_err++;
                    $display("FAIL fill_write[%0d] addr %0d: got lat=%0d err=%b rdata=%h after=%b, expected 1 0 0 1",
                             i, a, lat, er, rd, ok);
                end
            end
        end
    endtask

    task automatic test_reset_priority();
        int lat, hb, zb; logic [31:0] rd; logic er, ok;
        rst = 1'b1;
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 7'd3;
        req_wdata[0] = ~mdl[0][3]; req_be[0] = 4'hF;
        @(negedge clk);
        n_vec++;
        if (req_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ready_in_reset: got %b, expected 0", req_ready[0]);
        end
        rst = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        xact(0, 1'b0, 7'd3, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (rd !== mdl[0][3] || er !== 1'b0) begin
            n_err++;
            $display("FAIL reset_blocks_write: got rdata=%h err=%b, expected %h 0", rd, er, mdl[0][3]);
        end
    endtask

    task automatic test_basic();
        int lat, hb, zb; logic [31:0] rd; logic er, ok;
        xact(0, 1'b1, 7'd5, 32'hDEADBEEF, 4'hF, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL basic_write: got lat=%0d err=%b rdata=%h, expected 1 0 0", lat, er, rd);
        end
        xact(0, 1'b0, 7'd5, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || zb !== 0) begin
            n_err++;
            $display("FAIL basic_read: got lat=%0d err=%b rdata=%h zero_bad=%0d, expected 2 0 deadbeef 0",
                     lat, er, rd, zb);
        end
    endtask

    task automatic test_byte_enable();
        int lat, hb, zb; logic [31:0] rd; logic er, ok;
        xact(0, 1'b1, 7'd7, 32'h11223344, 4'hF, 0, lat, rd, er, hb, zb, ok);
        xact(0, 1'b1, 7'd7, 32'hAABBCCDD, 4'b0101, 0, lat, rd, er, hb, zb, ok);
        xact(0, 1'b0, 7'd7, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (rd !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL byte_enable: got %h, expected 11bb33dd", rd);
        end
        xact(0, 1'b1, 7'd7, 32'hFFFFFFFF, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (lat !== 1 || er !== 1'b0) begin
            n_err++;
            $display("FAIL be_zero_response: got lat=%0d err=%b, expected 1 0", lat, er);
        end
        xact(0, 1'b0, 7'd7, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (rd !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL be_zero_no_write: got %h, expected 11bb33dd", rd);
        end
    endtask

    task automatic test_hold();
        int lat, hb, zb; logic [31:0] rd; logic er, ok;
        xact(0, 1'b0, 7'd5, 32'h0, 4'h0, 5, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (hb !== 0 || ok !== 1'b1 || rd !== 32'hDEADBEEF || lat !== 2) begin
            n_err++;
            $display("FAIL hold_response: got hold_bad=%0d after=%b rdata=%h lat=%0d, expected 0 1 deadbeef 2",
                     hb, ok, rd, lat);
        end
        xact(3, 1'b0, 7'd90, 32'h0, 4'h0, 5, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (hb !== 0 || ok !== 1'b1 || rd !== mdl[3][90] || lat !== 7) begin
            n_err++;
            $display("FAIL hold_lat7: got hold_bad=%0d after=%b rdata=%h lat=%0d, expected 0 1 %h 7",
                     hb, ok, rd, lat, mdl[3][90]);
        end
    endtask

    task automatic test_out_of_range();
        int lat, hb, zb; logic [31:0] rd; logic er, ok;
        logic [31:0] w36;
        w36 = mdl[0][36];
        xact(0, 1'b1, 7'd100, 32'hCAFEF00D, 4'hF, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            n_err++;
            $display("FAIL oor_write: got err=%b rdata=%h lat=%0d, expected 1 0 1", er, rd, lat);
        end
        xact(0, 1'b0, 7'd36, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (rd !== w36 || er !== 1'b0) begin
            n_err++;
            $display("FAIL no_alias_word36: got %h err=%b, expected %h 0", rd, er, w36);
        end
        xact(0, 1'b0, 7'd100, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
            n_err++;
            $display("FAIL oor_read: got err=%b rdata=%h lat=%0d, expected 1 0 2", er, rd, lat);
        end
        xact(0, 1'b0, 7'd64, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL oor_boundary64: got err=%b rdata=%h, expected 1 0", er, rd);
        end
        xact(0, 1'b0, 7'd63, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (er !== 1'b0 || rd !== mdl[0][63]) begin
            n_err++;
            $display("FAIL inrange_boundary63: got err=%b rdata=%h, expected 0 %h", er, rd, mdl[0][63]);
        end
    endtask

    task automatic test_random();
        int lat, hb, zb, i, hold, exp_lat; logic [31:0] rd, wd, exp_rd; logic er, ok, wr, exp_err;
        logic [6:0] addr; logic [3:0] be;
        for (int k = 0; k < 150; k++) begin
            i = $urandom_range(0, NI - 1);
            wr = 1'($urandom); addr = 7'($urandom_range(0, 127));
            wd = $urandom; be = 4'($urandom); hold = $urandom_range(0, 3);
            exp_err = (int'(addr) >= nw_of(i));
            exp_rd  = (!wr && !exp_err) ? mdl[i][addr] : 32'h0;
            exp_lat = wr ? 1 : lat_of(i);
            xact(i, wr, addr, wd, be, hold, lat, rd, er, hb, zb, ok);
            n_vec++;
            if (lat !== exp_lat || rd !== exp_rd || er !== exp_err) begin
                n_err++;
                $display("FAIL rand_resp[%0d] inst %0d wr=%b addr=%0d: got lat=%0d rdata=%h err=%b, expected %0d %h %b",
                         k, i, wr, addr, lat, rd, er, exp_lat, exp_rd, exp_err);
            end
            n_vec++;
            if (hb !== 0 || zb !== 0 || ok !== 1'b1) begin
                n_err++;
                $display("FAIL rand_protocol[%0d] inst %0d: got hold_bad=%0d zero_bad=%0d after=%b, expected 0 0 1",
                         k, i, hb, zb, ok);
            end
        end
    endtask

    task automatic test_rst_abort();
        int lat, hb, zb, seen; logic [31:0] rd; logic er, ok;
        logic [31:0] exp10;
        exp10 = mdl[2][10];
        req_valid[2] = 1'b1; req_wr[2] = 1'b0; req_addr[2] = 7'd20; rsp_ready[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        n_vec++;
        if (busy[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_rdwait: got busy=%b valid=%b, expected 1 0", busy[2], rsp_valid[2]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready[2] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: got %b, expected 1", req_ready[2]);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid[2] === 1'b1) seen++;
            @(negedge clk);
        end
        rsp_ready[2] = 1'b0;
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_no_response: got %0d valid cycles, expected 0", seen);
        end
        xact(2, 1'b0, 7'd10, 32'h0, 4'h0, 0, lat, rd, er, hb, zb, ok);
        n_vec++;
        if (rd !== exp10 || lat !== 4) begin
            n_err++;
            $display("FAIL abort_data_kept: got rdata=%h lat=%0d, expected %h 4", rd, lat, exp10);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] exp;
        int last, cyc, nacc, lat;
        logic acc_prev;
        for (int i = 1; i < NI; i++) begin
            lat = lat_of(i);
            q.delete(); last = -1; cyc = 0; nacc = 0; acc_prev = 1'b0;
            rsp_ready[i] = 1'b1; req_valid[i] = 1'b1; req_wr[i] = 1'b0;
            req_addr[i] = 7'($urandom_range(0, 127));
            for (int c = 0; c < 6 * (lat + 1) + 2; c++) begin
                if (rsp_valid[i] === 1'b1) begin
                    exp = (q.size() > 0) ? q.pop_front() : 32'hx;
                    n_vec++;
                    if (rsp_rdata[i] !== exp) begin
                        n_err++;
                        $display("FAIL b2b_data lat %0d: got %h, expected %h", lat, rsp_rdata[i], exp);
                    end
                end
                if (acc_prev) req_addr[i] = 7'($urandom_range(0, 127));
                acc_prev = 1'b0;
                if (req_ready[i] === 1'b1) begin
                    if (last >= 0) begin
                        n_vec++;
                        if (cyc - last !== lat + 1) begin
                            n_err++;
                            $display("FAIL b2b_spacing lat %0d: got %0d, expected %0d", lat, cyc - last, lat + 1);
                        end
                    end
                    last = cyc; nacc++; acc_prev = 1'b1;
                    q.push_back(mdl[i][req_addr[i]]);
                end
                @(negedge clk);
                cyc++;
            end
            req_valid[i] = 1'b0;
            for (int c = 0; c < 20 && q.size() > 0; c++) begin
                if (rsp_valid[i] === 1'b1) begin
                    exp = q.pop_front();
                    n_vec++;
                    if (rsp_rdata[i] !== exp) begin
                        n_err++;
                        $display("FAIL b2b_drain lat %0d: got %h, expected %h", lat, rsp_rdata[i], exp);
                    end
                end
                @(negedge clk);
            end
            rsp_ready[i] = 1'b0;
            n_vec++;
            if (q.size() !== 0 || nacc < 5) begin
                n_err++;
                $display("FAIL b2b_count lat %0d: got pending=%0d accepts=%0d, expected 0 and >=5",
                         lat, q.size(), nacc);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_wr = '0; rsp_ready = '0;
        for (int i = 0; i < NI; i++) begin
            req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
            for (int a = 0; a < 128; a++) mdl[i][a] = '0;
        end
        @(negedge clk);
        test_reset();
        test_fill();
        test_reset_priority();
        test_basic();
        test_byte_enable();
        test_hold();
        test_out_of_range();
        test_random();
        test_rst_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
